pm_loader: RTL and testbench

PM_LOADER -- requirements
Module: pm_loader

---
 rtl/pm_loader_pkg.sv | 40 ++++
 rtl/pm_loader.sv | 119 +++++++++++
 tb/tb_pm_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pm_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pm_loader_pkg
// Description : Shared processor constants: loader FSM encodings, HALT word,
//               and instruction opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package pm_loader_pkg;

  // Loader FSM encodings
  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_low    = 3'd1;
  localparam logic [2:0] c_st_high   = 3'd2;
  localparam logic [2:0] c_st_write  = 3'd3;
  localparam logic [2:0] c_st_finish = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = c_st_idle,
    LOW    = c_st_low,
    HIGH   = c_st_high,
    WRITE  = c_st_write,
    FINISH = c_st_finish
  } state_t;

  localparam logic [15:0] c_halt_word = 16'h0000;

  // Processor opcodes (instruction bits [15:12])
  localparam logic [3:0] c_op_halt  = 4'h0;
  localparam logic [3:0] c_op_load  = 4'h1;
  localparam logic [3:0] c_op_store = 4'h2;
  localparam logic [3:0] c_op_add   = 4'h3;
  localparam logic [3:0] c_op_sub   = 4'h4;
  localparam logic [3:0] c_op_and   = 4'h5;
  localparam logic [3:0] c_op_or    = 4'h6;
  localparam logic [3:0] c_op_jump  = 4'h7;
  localparam logic [3:0] c_op_jz    = 4'h8;
  localparam logic [3:0] c_op_nop   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/pm_loader.sv
`default_nettype none
// ============================================================================
// Module      : pm_loader
// Description : Assembles little-endian byte pairs from a serial receiver into
//               program-memory words and writes them until HALT or full.
// Revision    : 1.0 - initial release
// ============================================================================
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int                     MEM_SIZE    = 9,
  parameter int                     ADDR_LENGTH = 11,
  parameter int                     DATA_LENGTH = 16,
  parameter int                     BYTE_WIDTH  = 8,
  parameter logic [DATA_LENGTH-1:0] HALT_WORD   = DATA_LENGTH'(c_halt_word)
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [BYTE_WIDTH-1:0]  i_RxData,
  input  logic                   i_RxValid,
  output logic                   o_WrEn,
  output logic [ADDR_LENGTH-1:0] o_WrAddr,
  output logic [DATA_LENGTH-1:0] o_WrData,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Error,
  output logic [ADDR_LENGTH:0]   o_WordCount
);

  localparam logic [ADDR_LENGTH:0] c_mem_size = (ADDR_LENGTH+1)'(MEM_SIZE);

  state_t                 r_state;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [ADDR_LENGTH:0]   r_count;
  logic [DATA_LENGTH-1:0] r_data;
  logic                   r_wr_en;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic [ADDR_LENGTH:0]   w_count_next;

  assign w_count_next = r_count + (ADDR_LENGTH+1)'(1);

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          if (i_Start) begin
            r_state <= LOW;
            r_addr  <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        LOW: begin
          if (i_RxValid) begin
            r_data[BYTE_WIDTH-1:0] <= i_RxData;
            r_state                <= HIGH;
          end
        end
        HIGH: begin
          if (i_RxValid) begin
            r_data[2*BYTE_WIDTH-1:BYTE_WIDTH] <= i_RxData;
            r_wr_en                           <= 1'b1;
            r_state                           <= WRITE;
          end
        end
        WRITE: begin
          r_wr_en <= 1'b0;
          r_addr  <= r_addr + ADDR_LENGTH'(1);
          r_count <= w_count_next;
          if (r_data == HALT_WORD) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_count_next == c_mem_size) begin
            r_state <= FINISH;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else if (i_RxValid) begin
            // Streaming receiver: the next low byte may arrive while writing
            r_data[BYTE_WIDTH-1:0] <= i_RxData;
            r_state                <= HIGH;
          end else begin
            r_state <= LOW;
          end
        end
        default: begin
          r_state <= IDLE;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_WrEn      = r_wr_en;
  assign o_WrAddr    = r_addr;
  assign o_WrData    = r_data;
  assign o_Busy      = r_busy;
  assign o_Done      = r_done;
  assign o_Error     = r_error;
  assign o_WordCount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pm_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pm_loader
// Description : Self-checking bench for pm_loader with a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pm_loader;
  import pm_loader_pkg::*;

  localparam int MEM_SIZE    = 9;
  localparam int ADDR_LENGTH = 11;
  localparam int DATA_LENGTH = 16;
  localparam int BYTE_WIDTH  = 8;

  logic                   clk;
  logic                   rst_n;
  logic                   start;
  logic [BYTE_WIDTH-1:0]  rx_data;
  logic                   rx_valid;
  logic                   wr_en;
  logic [ADDR_LENGTH-1:0] wr_addr;
  logic [DATA_LENGTH-1:0] wr_data;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [ADDR_LENGTH:0]   word_count;

  int checks_total;
  int checks_passed;
  int write_count;
  logic [ADDR_LENGTH-1:0] exp_addr;
  logic [ADDR_LENGTH+DATA_LENGTH-1:0] exp_q[$];

  pm_loader #(
    .MEM_SIZE   (MEM_SIZE),
    .ADDR_LENGTH(ADDR_LENGTH),
    .DATA_LENGTH(DATA_LENGTH),
    .BYTE_WIDTH (BYTE_WIDTH),
    .HALT_WORD  (16'h0000)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst_n),
    .i_Start    (start),
    .i_RxData   (rx_data),
    .i_RxValid  (rx_valid),
    .o_WrEn     (wr_en),
    .o_WrAddr   (wr_addr),
    .o_WrData   (wr_data),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Error    (error),
    .o_WordCount(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest pending expectation
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [ADDR_LENGTH+DATA_LENGTH-1:0] e;
      write_count++;
      checks_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%0d data=%h, want no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e)
          $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                   wr_addr, wr_data, e[ADDR_LENGTH+DATA_LENGTH-1:DATA_LENGTH], e[DATA_LENGTH-1:0]);
        else
          checks_passed++;
      end
      checks_total++;
      if (wr_addr >= ADDR_LENGTH'(MEM_SIZE))
        $display("FAIL addr_bound: got addr=%0d, want < %0d", wr_addr, MEM_SIZE);
      else
        checks_passed++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    exp_q.push_back({exp_addr, w});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 60 && !(done === 1'b1 || error === 1'b1); i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks_total++;
    if ({wr_en, busy, done, error} !== 4'b0000)
      $display("FAIL reset_flags: got wr_en/busy/done/error=%b, want 0000", {wr_en, busy, done, error});
    else checks_passed++;
    checks_total++;
    if (wr_addr !== '0) $display("FAIL reset_addr: got %0d, want 0", wr_addr);
    else checks_passed++;
    checks_total++;
    if (word_count !== '0) $display("FAIL reset_count: got %0d, want 0", word_count);
    else checks_passed++;
    checks_total++;
    if (wr_data !== '0) $display("FAIL reset_data: got %h, want 0000", wr_data);
    else checks_passed++;
    checks_total++;
    if (dut.r_state !== IDLE) $display("FAIL reset_state: got %0d, want %0d", dut.r_state, IDLE);
    else checks_passed++;
  endtask

  task automatic test_halt_load();
    pulse_start();
    checks_total++;
    if (busy !== 1'b1) $display("FAIL halt_busy: got %b, want 1", busy);
    else checks_passed++;
    send_word(16'h1234);
    tick();
    send_word(16'h5678);
    tick();
    send_word(16'h0000);
    wait_finish();
    checks_total++;
    if ({done, error, busy} !== 3'b100)
      $display("FAIL halt_flags: got done/error/busy=%b, want 100", {done, error, busy});
    else checks_passed++;
    checks_total++;
    if (word_count !== 12'd3) $display("FAIL halt_count: got %0d, want 3", word_count);
    else checks_passed++;
    checks_total++;
    if (exp_q.size() != 0) $display("FAIL halt_pending: got %0d pending writes, want 0", exp_q.size());
    else checks_passed++;
  endtask

  task automatic test_overflow();
    int writes_before;
    writes_before = write_count;
    pulse_start();
    for (int i = 0; i < MEM_SIZE; i++) send_word(16'hA000 + 16'(i) + 16'd1);
    wait_finish();
    checks_total++;
    if ({done, error, busy} !== 3'b010)
      $display("FAIL ovf_flags: got done/error/busy=%b, want 010", {done, error, busy});
    else checks_passed++;
    checks_total++;
    if (word_count !== 12'd9) $display("FAIL ovf_count: got %0d, want 9", word_count);
    else checks_passed++;
    // Bytes after the error must not produce a 10th write
    send_byte(8'h55);
    send_byte(8'h66);
    repeat (3) tick();
    checks_total++;
    if (write_count - writes_before != MEM_SIZE)
      $display("FAIL ovf_writes: got %0d writes, want %0d", write_count - writes_before, MEM_SIZE);
    else checks_passed++;
    checks_total++;
    if (error !== 1'b1 || word_count !== 12'd9)
      $display("FAIL ovf_hold: got error=%b count=%0d, want error=1 count=9", error, word_count);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    pulse_start();
    send_word(16'hBEEF);
    send_word(16'hCAFE);
    send_word(16'h0000);
    wait_finish();
    checks_total++;
    if ({done, error} !== 2'b10) $display("FAIL b2b_flags: got done/error=%b, want 10", {done, error});
    else checks_passed++;
    checks_total++;
    if (word_count !== 12'd3) $display("FAIL b2b_count: got %0d, want 3", word_count);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'hCD);
    rst_n = 1'b0;
    tick();
    checks_total++;
    if ({wr_en, busy} !== 2'b00) $display("FAIL midrst_flags: got wr_en/busy=%b, want 00", {wr_en, busy});
    else checks_passed++;
    checks_total++;
    if (dut.r_state !== IDLE) $display("FAIL midrst_state: got %0d, want %0d", dut.r_state, IDLE);
    else checks_passed++;
    rst_n = 1'b1;
    tick();
    checks_total++;
    if (wr_en !== 1'b0) $display("FAIL midrst_after: got wr_en=%b, want 0", wr_en);
    else checks_passed++;
    pulse_start();
    send_word(16'hABCD);
    send_word(16'h0000);
    wait_finish();
    checks_total++;
    if (done !== 1'b1 || word_count !== 12'd2)
      $display("FAIL midrst_reload: got done=%b count=%0d, want done=1 count=2", done, word_count);
    else checks_passed++;
  endtask

  task automatic test_ignored();
    int writes_before;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    writes_before = write_count;
    send_byte(8'h77);
    tick();
    checks_total++;
    if (dut.r_state !== IDLE || wr_addr !== '0 || busy !== 1'b0)
      $display("FAIL idle_rx: got state=%0d addr=%0d busy=%b, want state=%0d addr=0 busy=0",
               dut.r_state, wr_addr, busy, IDLE);
    else checks_passed++;
    pulse_start();
    send_byte(8'h11);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks_total++;
    if (dut.r_state !== HIGH || wr_addr !== '0 || busy !== 1'b1)
      $display("FAIL high_start: got state=%0d addr=%0d busy=%b, want state=%0d addr=0 busy=1",
               dut.r_state, wr_addr, busy, HIGH);
    else checks_passed++;
    checks_total++;
    if (write_count != writes_before)
      $display("FAIL ignored_writes: got %0d writes, want 0", write_count - writes_before);
    else checks_passed++;
    send_byte(8'h22);
    exp_q.push_back({exp_addr, 16'h2211});
    exp_addr = exp_addr + 1'b1;
    send_word(16'h0000);
    wait_finish();
    checks_total++;
    if (done !== 1'b1 || word_count !== 12'd2)
      $display("FAIL ignored_finish: got done=%b count=%0d, want done=1 count=2", done, word_count);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    write_count   = 0;
    exp_addr      = '0;
    rst_n         = 1'b0;
    start         = 1'b0;
    rx_data       = '0;
    rx_valid      = 1'b0;
    tick();
    test_reset();
    test_halt_load();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_ignored();
    repeat (3) tick();
    checks_total++;
    if (exp_q.size() != 0) $display("FAIL final_pending: got %0d pending writes, want 0", exp_q.size());
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
